mdio_slave: RTL and testbench
=============================

// Module: mdio_slave
// PURPOSE
//  PHY-side MDIO responder (IEEE 802.3 clause 22) with a 32x16 register file. Oversamples
//  asynchronous MDC/MDIO on clk, decodes read/write frames for its PHY address, drives
//  read data back through a tristate split (mdio_o/mdio_t, pad at top level). Serves as
//  the PHY emulation target for mdio_master in loopback benches and FPGA PHY emulation.
// PARAMETERS
//  PHY_ADDRESS   5'h0c     address this responder answers to; others are ignored
//  MIN_PREAMBLE  0         consecutive 1 bits required before start; 0 = preamble suppression
//  SYNC_STAGES   2         flops in MDC/MDIO synchronizers (>=2)
//  PHY_ID1       16'h2000  read-only value of reg 2
//  PHY_ID2       16'h5c90  read-only value of reg 3
// PORTS
//  clk           in   1   system clock, >= 8x MDC frequency
//  reset         in   1   synchronous, active-high
//  mdc_i         in   1   MDC from station, asynchronous
//  mdio_i        in   1   MDIO pad input, asynchronous
//  mdio_o        out  1   MDIO drive value
//  mdio_t        out  1   1 = tristate (released), 0 = driving
//  status_i      in   16  live value returned for reg 1 (read-only)
//  reg_wr_valid  out  1   1-clk pulse on committed frame write
//  reg_wr_addr   out  5   register address of that write
//  reg_wr_data   out  16  data of that write
//  busy          out  1   high whenever FSM not in IDLE
// BEHAVIOUR
//  Reset: mdio_t=1, mdio_o=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0, FSM IDLE,
//   writable regs (0,4..31) = 16'h0000, preamble count 0. Mid-frame reset releases MDIO next clk.
//  Edges: rise/fall = synchronized MDC transitions, one-clk strobes, SYNC_STAGES+1 clk latency.
//   MDIO sampled (synchronized) at rise; slave output changes only at fall.
//  FSM (advances on rise unless noted):
//   IDLE: 1 -> ones count++ (saturating, 6b); 0 with count>=MIN_PREAMBLE -> START, else count=0.
//   START: 1 -> HEADER; 0 -> IDLE, count=0.
//   HEADER: shift 12 bits MSB-first {op[1:0],phyad[4:0],regad[4:0]}. After 12th bit:
//    op=10 & phyad match -> READ_TA, latch read word; op=01 & match -> WRITE_TA;
//    else (op 00/11 or mismatch) -> IGNORE.
//   READ_TA/READ_DATA (fall-counted after header): fall1 keep Z; fall2 mdio_t=0,mdio_o=0;
//    falls 3..18 drive data[15..0]; fall19 mdio_t=1 -> IDLE, count=0.
//   WRITE_TA: expect 1 then 0 on next two rises; mismatch -> IGNORE (remaining bits).
//   WRITE_DATA: shift 16 bits; after 16th rise, commit and pulse reg_wr_valid next clk.
//   IGNORE: consume remaining bits up to 18 after header, never drive -> IDLE.
//  Read word: reg1 = status_i sampled at header completion; reg2/3 = PHY_ID1/2; others = regfile.
//  Writes: regs 1,2,3 discarded (pulse still issued). reg0 bit15 = soft reset: writing 1 clears
//   all writable regs to 0 (incl. reg0); bit15 always reads 0.
//  reg_wr_valid pulse also fires for discarded writes; addr/data hold until next write.
//  Header/data counters 5b; ones counter saturates at 63 (no wrap).
//  MDC stopping mid-frame: FSM holds state indefinitely; only reset or new edges advance it.
// STRUCTURE
//  mdio_pkg: MDIO_READ_OPCODE=2'b10, MDIO_WRITE_OPCODE=2'b01, TA constant 2'b10, state enum,
//   reg index constants (BMCR=0, BMSR=1, PHYID1=2, PHYID2=3), shared with mdio_master.
//  Sub-module mdio_edge_sync: SYNC_STAGES synchronizer for mdc_i/mdio_i + rise/fall strobes.
//  Top: FSM, header/data shift regs, bit counters, 29x16 regfile.
// TESTING
//  mdio_master write reg 4 = 16'hA5C3 -> reg_wr_valid once, addr 4, data A5C3; read 4 returns A5C3.
//  status_i=16'h796D, master read reg 1 -> rdata 796D; mdio_t=0 for exactly 17 MDC periods.
//  Read reg 2/3 -> 2000/5C90; write 16'hFFFF to reg 2 then read -> still 2000, pulse seen.
//  Frame to PHY addr 5'h01 (write reg 4 = 1234, then read) -> mdio_t stays 1, reg 4 unchanged.
//  MIN_PREAMBLE=32: 31 ones then frame -> ignored; 32 ones then frame -> accepted.
//  Write reg0=16'h8000 after reg5=16'h00FF -> reg5 and reg0 read 0000; reset mid-read -> mdio_t=1 next clk.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared MDIO clause-22 definitions: opcodes, turnaround pattern, FSM states,
// standard register indices and the register-file index mapping.
package mdio_pkg;

  localparam logic [1:0] MDIO_READ_OPCODE  = 2'b10;
  localparam logic [1:0] MDIO_WRITE_OPCODE = 2'b01;
  localparam logic [1:0] MDIO_TA           = 2'b10;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;

  // Backing storage exists only for reg 0 and regs 4..31
  localparam int REGFILE_DEPTH = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HEADER,
    ST_READ_TA,
    ST_READ_DATA,
    ST_WRITE_TA,
    ST_WRITE_DATA,
    ST_IGNORE
  } mdio_state_t;

  // Map a register address onto the compact storage array (0 -> 0, 4..31 -> 1..28)
  function automatic logic [4:0] regfile_index(input logic [4:0] regad);
    if (regad < 5'd4) return 5'd0;
    else              return regad - 5'd3;
  endfunction

  // Registers 1..3 are read-only; everything else has storage
  function automatic logic is_writable(input logic [4:0] regad);
    return (regad == REG_BMCR) || (regad >= 5'd4);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings the asynchronous MDC/MDIO pins into the clk domain and produces
// one-clk rise/fall strobes of MDC with the MDIO sample aligned to them.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic rise,
  output logic fall,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_prev;

  // Shift both pins through their synchronizer chains and register the edge strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_prev  <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      mdio_s    <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_prev  <= mdc_sync[SYNC_STAGES-1];
      rise      <= mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
      fall      <= ~mdc_sync[SYNC_STAGES-1] & mdc_prev;
      mdio_s    <= mdio_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/mdio_slave.sv
// Clause-22 MDIO PHY responder: decodes frames addressed to PHY_ADDRESS,
// serves reads from a small register file plus fixed ID/status registers,
// and commits writes with a one-clk notification pulse.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDRESS  = 5'h0c,
  parameter int          MIN_PREAMBLE = 0,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] PHY_ID1      = 16'h2000,
  parameter logic [15:0] PHY_ID2      = 16'h5c90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [15:0] status_i,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);

  logic rise;
  logic fall;
  logic mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .mdc_i  (mdc_i),
    .mdio_i (mdio_i),
    .rise   (rise),
    .fall   (fall),
    .mdio_s (mdio_s)
  );

  mdio_state_t state;
  logic [5:0]  ones_cnt;
  logic [4:0]  bit_cnt;
  logic [10:0] hdr_shift;
  logic [15:0] data_shift;
  logic [4:0]  wr_reg;
  logic [15:0] regfile [REGFILE_DEPTH];

  logic [11:0] hdr_full;
  logic [15:0] wr_word;
  logic [15:0] read_word;
  logic        ta_expect;
  logic        phy_match;

  assign hdr_full  = {hdr_shift, mdio_s};
  assign wr_word   = {data_shift[14:0], mdio_s};
  assign ta_expect = (bit_cnt == 5'd0) ? MDIO_TA[1] : MDIO_TA[0];
  assign phy_match = (hdr_full[9:5] == PHY_ADDRESS);
  assign busy      = (state != ST_IDLE);

  // Word returned for the register named by the header that is just completing
  always_comb begin
    read_word = regfile[regfile_index(hdr_full[4:0])];
    case (hdr_full[4:0])
      REG_BMSR:   read_word = status_i;
      REG_PHYID1: read_word = PHY_ID1;
      REG_PHYID2: read_word = PHY_ID2;
      default:    ;
    endcase
  end

  // Frame FSM: sampling on MDC rise, driving on MDC fall, register file updates on write commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      hdr_shift    <= '0;
      data_shift   <= '0;
      wr_reg       <= '0;
      mdio_o       <= 1'b0;
      mdio_t       <= 1'b1;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      for (int i = 0; i < REGFILE_DEPTH; i++) regfile[i] <= '0;
    end else begin
      reg_wr_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            if (mdio_s) begin
              if (ones_cnt != 6'd63) ones_cnt <= ones_cnt + 6'd1;
            end else if (int'(ones_cnt) >= MIN_PREAMBLE) begin
              state <= ST_START;
            end else begin
              ones_cnt <= '0;
            end
          end
        end
        ST_START: begin
          if (rise) begin
            if (mdio_s) begin
              state   <= ST_HEADER;
              bit_cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              ones_cnt <= '0;
            end
          end
        end
        ST_HEADER: begin
          if (rise) begin
            hdr_shift <= hdr_full[10:0];
            if (bit_cnt == 5'd11) begin
              bit_cnt <= '0;
              if (phy_match && hdr_full[11:10] == MDIO_READ_OPCODE) begin
                state      <= ST_READ_TA;
                data_shift <= read_word;
              end else if (phy_match && hdr_full[11:10] == MDIO_WRITE_OPCODE) begin
                state  <= ST_WRITE_TA;
                wr_reg <= hdr_full[4:0];
              end else begin
                state <= ST_IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_READ_TA: begin
          if (fall) begin
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              mdio_t  <= 1'b0;
              mdio_o  <= MDIO_TA[0];
              bit_cnt <= '0;
              state   <= ST_READ_DATA;
            end
          end
        end
        ST_READ_DATA: begin
          if (fall) begin
            if (bit_cnt == 5'd16) begin
              mdio_t   <= 1'b1;
              mdio_o   <= 1'b0;
              bit_cnt  <= '0;
              ones_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              mdio_o     <= data_shift[15];
              data_shift <= {data_shift[14:0], 1'b0};
              bit_cnt    <= bit_cnt + 5'd1;
            end
          end
        end
        ST_WRITE_TA: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (mdio_s != ta_expect) state <= ST_IGNORE;
            else if (bit_cnt == 5'd1) state <= ST_WRITE_DATA;
          end
        end
        ST_WRITE_DATA: begin
          if (rise) begin
            data_shift <= wr_word;
            if (bit_cnt == 5'd17) begin
              reg_wr_valid <= 1'b1;
              reg_wr_addr  <= wr_reg;
              reg_wr_data  <= wr_word;
              if (wr_reg == REG_BMCR && wr_word[15]) begin
                for (int i = 0; i < REGFILE_DEPTH; i++) regfile[i] <= '0;
              end else if (wr_reg == REG_BMCR) begin
                regfile[0] <= {1'b0, wr_word[14:0]};
              end else if (is_writable(wr_reg)) begin
                regfile[regfile_index(wr_reg)] <= wr_word;
              end
              bit_cnt  <= '0;
              ones_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_IGNORE: begin
          if (rise) begin
            if (bit_cnt == 5'd17) begin
              bit_cnt  <= '0;
              ones_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          mdio_t <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: a behavioural MDIO station drives frames,
// a spec-level register model predicts read data and write notifications.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        master_oe;
  logic        master_bit;
  logic [15:0] status;
  wire         mdio_line;

  logic        mdio_o0, mdio_t0, wr_valid0, busy0;
  logic [4:0]  wr_addr0;
  logic [15:0] wr_data0;
  logic        mdio_o1, mdio_t1, wr_valid1, busy1;
  logic [4:0]  wr_addr1;
  logic [15:0] wr_data1;

  int checks_total  = 0;
  int checks_passed = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  logic [15:0] model_regs [32];

  typedef struct {
    logic        is_write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] status;
    logic [15:0] exp_rdata;
    int          exp_pulses;
    int          exp_drive;
  } vec_t;

  vec_t vecs [17];

  // Open-drain style bus: station drives when enabled, else the PHY, else the pull-up
  assign mdio_line = master_oe ? master_bit : (mdio_t0 ? 1'b1 : mdio_o0);

  always #5 clk = ~clk;

  mdio_slave #(.PHY_ADDRESS(5'h0c), .MIN_PREAMBLE(0)) dut0 (
    .clk(clk), .reset(reset), .mdc_i(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o0), .mdio_t(mdio_t0), .status_i(status),
    .reg_wr_valid(wr_valid0), .reg_wr_addr(wr_addr0), .reg_wr_data(wr_data0),
    .busy(busy0)
  );

  mdio_slave #(.PHY_ADDRESS(5'h0c), .MIN_PREAMBLE(32)) dut1 (
    .clk(clk), .reset(reset), .mdc_i(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o1), .mdio_t(mdio_t1), .status_i(status),
    .reg_wr_valid(wr_valid1), .reg_wr_addr(wr_addr1), .reg_wr_data(wr_data1),
    .busy(busy1)
  );

  // Count clk cycles with the write-notify pulse high, so a stretched pulse shows up as extra
  always @(negedge clk) begin
    if (wr_valid0) pulses0++;
    if (wr_valid1) pulses1++;
  end

  // Safety net so a wedged run still ends
  initial begin
    #50000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Register behaviour as seen from the station
  task automatic modelWrite(input logic [4:0] regad, input logic [15:0] data);
    if (regad == 5'd1 || regad == 5'd2 || regad == 5'd3) return;
    if (regad == 5'd0 && data[15]) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    end else if (regad == 5'd0) begin
      model_regs[0] = data & 16'h7fff;
    end else begin
      model_regs[regad] = data;
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [4:0] regad, input logic [15:0] st);
    case (regad)
      5'd1:    return st;
      5'd2:    return 16'h2000;
      5'd3:    return 16'h5c90;
      default: return model_regs[regad];
    endcase
  endfunction

  // One MDC period: low half with data presented, sample just before the rise, high half
  task automatic mdcBit(input logic drive, input logic value, output logic sampled, output logic slave_drv);
    master_oe  = drive;
    master_bit = value;
    repeat (5) @(posedge clk);
    #1;
    sampled   = mdio_line;
    slave_drv = !mdio_t0;
    mdc = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    mdc = 1'b0;
  endtask

  // Whole clause-22 frame; returns read word and the number of bits the PHY drove
  task automatic applyStimulus(input logic is_write, input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] wdata, input int pre_len,
                               output logic [15:0] rdata, output int drive_bits);
    logic        s, d;
    logic [13:0] hdr;
    logic [15:0] st_hold;
    drive_bits = 0;
    rdata      = 16'h0000;
    hdr = {2'b01, (is_write ? 2'b01 : 2'b10), phy, regad};
    for (int i = 0; i < pre_len; i++) begin
      mdcBit(1'b1, 1'b1, s, d);
      if (d) drive_bits++;
    end
    for (int i = 13; i >= 0; i--) begin
      mdcBit(1'b1, hdr[i], s, d);
      if (d) drive_bits++;
    end
    if (is_write) begin
      mdcBit(1'b1, 1'b1, s, d);
      if (d) drive_bits++;
      mdcBit(1'b1, 1'b0, s, d);
      if (d) drive_bits++;
      for (int i = 15; i >= 0; i--) begin
        mdcBit(1'b1, wdata[i], s, d);
        if (d) drive_bits++;
      end
    end else begin
      st_hold = status;
      status  = ~status;
      for (int i = 0; i < 2; i++) begin
        mdcBit(1'b0, 1'b1, s, d);
        if (d) drive_bits++;
      end
      for (int i = 0; i < 16; i++) begin
        mdcBit(1'b0, 1'b1, s, d);
        if (d) drive_bits++;
        rdata = {rdata[14:0], s};
      end
      status = st_hold;
    end
    master_oe  = 1'b1;
    master_bit = 1'b1;
  endtask

  initial begin
    logic [15:0] rdata;
    int          drv;
    int          p0, p1;
    logic        is_write, s, d;
    logic [4:0]  phy, regad;
    logic [15:0] wdata, exp_rdata;
    logic        accepted;
    logic [13:0] hdr;

    reset      = 1'b1;
    mdc        = 1'b0;
    master_oe  = 1'b1;
    master_bit = 1'b1;
    status     = 16'h0000;
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;

    vecs[0]  = '{1'b1, 5'h0c, 5'd4, 16'hA5C3, 16'h0000, 16'h0000, 1, 0};
    vecs[1]  = '{1'b0, 5'h0c, 5'd4, 16'h0000, 16'h0000, 16'hA5C3, 0, 17};
    vecs[2]  = '{1'b0, 5'h0c, 5'd1, 16'h0000, 16'h796D, 16'h796D, 0, 17};
    vecs[3]  = '{1'b0, 5'h0c, 5'd2, 16'h0000, 16'h0000, 16'h2000, 0, 17};
    vecs[4]  = '{1'b0, 5'h0c, 5'd3, 16'h0000, 16'h0000, 16'h5C90, 0, 17};
    vecs[5]  = '{1'b1, 5'h0c, 5'd2, 16'hFFFF, 16'h0000, 16'h0000, 1, 0};
    vecs[6]  = '{1'b0, 5'h0c, 5'd2, 16'h0000, 16'h0000, 16'h2000, 0, 17};
    vecs[7]  = '{1'b1, 5'h01, 5'd4, 16'h1234, 16'h0000, 16'h0000, 0, 0};
    vecs[8]  = '{1'b0, 5'h01, 5'd4, 16'h0000, 16'h0000, 16'hFFFF, 0, 0};
    vecs[9]  = '{1'b0, 5'h0c, 5'd4, 16'h0000, 16'h0000, 16'hA5C3, 0, 17};
    vecs[10] = '{1'b1, 5'h0c, 5'd5, 16'h00FF, 16'h0000, 16'h0000, 1, 0};
    vecs[11] = '{1'b0, 5'h0c, 5'd5, 16'h0000, 16'h0000, 16'h00FF, 0, 17};
    vecs[12] = '{1'b1, 5'h0c, 5'd0, 16'h8000, 16'h0000, 16'h0000, 1, 0};
    vecs[13] = '{1'b0, 5'h0c, 5'd5, 16'h0000, 16'h0000, 16'h0000, 0, 17};
    vecs[14] = '{1'b0, 5'h0c, 5'd0, 16'h0000, 16'h0000, 16'h0000, 0, 17};
    vecs[15] = '{1'b1, 5'h0c, 5'd0, 16'h7FFF, 16'h0000, 16'h0000, 1, 0};
    vecs[16] = '{1'b0, 5'h0c, 5'd0, 16'h0000, 16'h0000, 16'h7FFF, 0, 17};

    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset mdio_t", 32'(mdio_t0), 32'd1);
    checkOutput("reset mdio_o", 32'(mdio_o0), 32'd0);
    checkOutput("reset reg_wr_valid", 32'(wr_valid0), 32'd0);
    checkOutput("reset reg_wr_addr", 32'(wr_addr0), 32'd0);
    checkOutput("reset reg_wr_data", 32'(wr_data0), 32'd0);
    checkOutput("reset busy", 32'(busy0), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      status = vecs[i].status;
      p0 = pulses0;
      applyStimulus(vecs[i].is_write, vecs[i].phy, vecs[i].regad, vecs[i].wdata, 32, rdata, drv);
      repeat (4) @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d pulses", i), 32'(pulses0 - p0), 32'(vecs[i].exp_pulses));
      checkOutput($sformatf("vec%0d drive bits", i), 32'(drv), 32'(vecs[i].exp_drive));
      checkOutput($sformatf("vec%0d released", i), 32'(mdio_t0), 32'd1);
      checkOutput($sformatf("vec%0d idle", i), 32'(busy0), 32'd0);
      if (vecs[i].is_write && vecs[i].exp_pulses == 1) begin
        checkOutput($sformatf("vec%0d wr addr", i), 32'(wr_addr0), 32'(vecs[i].regad));
        checkOutput($sformatf("vec%0d wr data", i), 32'(wr_data0), 32'(vecs[i].wdata));
      end
      if (!vecs[i].is_write)
        checkOutput($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      if (vecs[i].is_write && vecs[i].phy == 5'h0c) modelWrite(vecs[i].regad, vecs[i].wdata);
    end

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      is_write = 1'($urandom_range(0, 1));
      phy      = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'h0c;
      regad    = 5'($urandom_range(0, 31));
      wdata    = 16'($urandom);
      if (regad == 5'd0 && $urandom_range(0, 3) != 0) wdata[15] = 1'b0;
      status   = 16'($urandom);
      accepted = (phy == 5'h0c);
      exp_rdata = accepted ? modelRead(regad, status) : 16'hFFFF;
      p0 = pulses0;
      applyStimulus(is_write, phy, regad, wdata, 32, rdata, drv);
      repeat (4) @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d pulses", n), 32'(pulses0 - p0), (accepted && is_write) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rnd%0d drive bits", n), 32'(drv), (accepted && !is_write) ? 32'd17 : 32'd0);
      if (is_write && accepted) begin
        checkOutput($sformatf("rnd%0d wr addr", n), 32'(wr_addr0), 32'(regad));
        checkOutput($sformatf("rnd%0d wr data", n), 32'(wr_data0), 32'(wdata));
        modelWrite(regad, wdata);
      end
      if (!is_write) checkOutput($sformatf("rnd%0d rdata", n), 32'(rdata), 32'(exp_rdata));
    end

    $display("[TB] minimum preamble");
    p1 = pulses1;
    applyStimulus(1'b1, 5'h0c, 5'd6, 16'h1230, 31, rdata, drv);
    modelWrite(5'd6, 16'h1230);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("preamble31 pulses", 32'(pulses1 - p1), 32'd0);
    checkOutput("preamble31 idle", 32'(busy1), 32'd0);
    p1 = pulses1;
    applyStimulus(1'b1, 5'h0c, 5'd6, 16'h1230, 32, rdata, drv);
    modelWrite(5'd6, 16'h1230);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("preamble32 pulses", 32'(pulses1 - p1), 32'd1);
    checkOutput("preamble32 wr addr", 32'(wr_addr1), 32'd6);
    checkOutput("preamble32 wr data", 32'(wr_data1), 32'h1230);

    $display("[TB] MDC stall and reset during read");
    status = 16'h0000;
    hdr = {2'b01, 2'b10, 5'h0c, 5'd6};
    for (int i = 0; i < 32; i++) mdcBit(1'b1, 1'b1, s, d);
    for (int i = 13; i >= 0; i--) mdcBit(1'b1, hdr[i], s, d);
    for (int i = 0; i < 6; i++) mdcBit(1'b0, 1'b1, s, d);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("stall still driving", 32'(mdio_t0), 32'd0);
    checkOutput("stall still busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midread reset mdio_t", 32'(mdio_t0), 32'd1);
    checkOutput("midread reset busy", 32'(busy0), 32'd0);
    reset = 1'b0;
    master_oe = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'h0c, 5'd6, 16'h0000, 32, rdata, drv);
    checkOutput("post reset rdata", 32'(rdata), 32'(modelRead(5'd6, status)));
    checkOutput("post reset drive bits", 32'(drv), 32'd17);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
